// File: rtl/instruction_fetch_unit.sv
// Fetch front end: drives the synchronous instruction memory and carries PCs down three stages.
// Optional FETCH_PERF_CNT_EN adds fetch/redirect performance counters.
module instruction_fetch_unit #(
    parameter logic [31:0]                 RESET_PC         = 32'h4000_0000,
    parameter int unsigned                 IMEM_AW          = 14,
    parameter int unsigned                 PC_MUX_SEL_WIDTH = 2,
    parameter logic [PC_MUX_SEL_WIDTH-1:0] PC_MUX_PLUS_4    = PC_MUX_SEL_WIDTH'(0),
    parameter logic [PC_MUX_SEL_WIDTH-1:0] PC_MUX_BRANCH    = PC_MUX_SEL_WIDTH'(1),
    parameter logic [PC_MUX_SEL_WIDTH-1:0] PC_MUX_J         = PC_MUX_SEL_WIDTH'(2)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        stall,
    input  logic [PC_MUX_SEL_WIDTH-1:0] pc_mux_sel,
    input  logic [31:0]                 branch_target,
    input  logic [31:0]                 jump_target,
    input  logic [31:0]                 imem_dout,
    output logic                        imem_en,
    output logic [IMEM_AW-1:0]          imem_addr,
    output logic [31:0]                 instruction_1,
    output logic [31:0]                 pc_1,
    output logic [31:0]                 pc_2,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                 pc_3_plus4,
    output logic [31:0]                 fetch_count,
    output logic [31:0]                 redirect_count
`else
    output logic [31:0]                 pc_3_plus4
`endif
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HOLD,
        S_HOLD_REDIR
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_1_q, pc_1_d;
    logic [31:0] pc_2_q, pc_2_d;
    logic [31:0] pc_3_plus4_q, pc_3_plus4_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;

    logic [31:0] next_pc;
    logic [31:0] live_tgt;
    logic        live_redir;
    logic        fetch_en;
    logic        bubble;
    logic        advance;
    logic        redir_issue;

    // Codes other than BRANCH/J fall back to sequential fetch.
    assign live_redir = (pc_mux_sel != PC_MUX_PLUS_4) &&
                        ((pc_mux_sel == PC_MUX_BRANCH) || (pc_mux_sel == PC_MUX_J));
    assign live_tgt   = (pc_mux_sel == PC_MUX_J) ? (jump_target   & 32'hFFFF_FFFC)
                                                 : (branch_target & 32'hFFFF_FFFC);

    always_comb begin
        state_d      = state_q;
        redir_tgt_d  = redir_tgt_q;
        next_pc      = pc_1_q + 32'd4;
        fetch_en     = 1'b0;
        bubble       = 1'b0;
        advance      = 1'b0;
        redir_issue  = 1'b0;

        case (state_q)
            S_BOOT: begin
                next_pc  = RESET_PC;
                fetch_en = 1'b1;
                bubble   = 1'b1;
                state_d  = S_RUN;
            end
            S_RUN, S_HOLD: begin
                if (stall) begin
                    if (live_redir) begin
                        redir_tgt_d = live_tgt;
                        state_d     = S_HOLD_REDIR;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    fetch_en = 1'b1;
                    advance  = 1'b1;
                    state_d  = S_RUN;
                    if (live_redir) begin
                        next_pc     = live_tgt;
                        redir_issue = 1'b1;
                    end
                end
            end
            S_HOLD_REDIR: begin
                if (stall) begin
                    if (live_redir) begin
                        redir_tgt_d = live_tgt;
                    end
                end else begin
                    // Held word is wrong-path; the latched target wins over pc_mux_sel.
                    next_pc     = redir_tgt_q;
                    fetch_en    = 1'b1;
                    advance     = 1'b1;
                    bubble      = 1'b1;
                    redir_issue = 1'b1;
                    redir_tgt_d = '0;
                    state_d     = S_RUN;
                end
            end
        endcase

        pc_1_d       = pc_1_q;
        pc_2_d       = pc_2_q;
        pc_3_plus4_d = pc_3_plus4_q;
        if (advance) begin
            pc_1_d       = next_pc;
            pc_2_d       = pc_1_q;
            pc_3_plus4_d = pc_2_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_BOOT;
            pc_1_q       <= RESET_PC;
            pc_2_q       <= RESET_PC;
            pc_3_plus4_q <= RESET_PC + 32'd4;
            redir_tgt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_1_q       <= pc_1_d;
            pc_2_q       <= pc_2_d;
            pc_3_plus4_q <= pc_3_plus4_d;
            redir_tgt_q  <= redir_tgt_d;
        end
    end

    // Enable is gated by rst_n so the memory stays idle for the whole reset.
    assign imem_en       = fetch_en & rst_n;
    assign imem_addr     = next_pc[IMEM_AW+1:2];
    assign instruction_1 = bubble ? '0 : imem_dout;
    assign pc_1          = pc_1_q;
    assign pc_2          = pc_2_q;
    assign pc_3_plus4    = pc_3_plus4_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count_q, redirect_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_q    <= '0;
            redirect_count_q <= '0;
        end else begin
            if (fetch_en)    fetch_count_q    <= fetch_count_q + 32'd1;
            if (redir_issue) redirect_count_q <= redirect_count_q + 32'd1;
        end
    end

    assign fetch_count    = fetch_count_q;
    assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan steps plus random
// stall/redirect traffic checked against a PC-sequence model. Honours FETCH_PERF_CNT_EN.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h4000_0000;
    localparam int          AW       = 14;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          stall = 1'b0;
    logic [1:0]    pc_mux_sel = 2'd0;
    logic [31:0]   branch_target = '0;
    logic [31:0]   jump_target = '0;
    logic [31:0]   imem_dout = '0;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   instruction_1, pc_1, pc_2, pc_3_plus4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]   fetch_count, redirect_count;
`endif

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_mux_sel    (pc_mux_sel),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem_dout     (imem_dout),
        .imem_en       (imem_en),
        .imem_addr     (imem_addr),
        .instruction_1 (instruction_1),
        .pc_1          (pc_1),
        .pc_2          (pc_2),
`ifdef FETCH_PERF_CNT_EN
        .pc_3_plus4    (pc_3_plus4),
        .fetch_count   (fetch_count),
        .redirect_count(redirect_count)
`else
        .pc_3_plus4    (pc_3_plus4)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction memory; output holds while disabled.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) if (imem_en) imem_dout <= mem[imem_addr];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: program-order PC history plus a pending-redirect record.
    bit          m_boot;
    bit          m_pend;
    logic [31:0] m_pc1, m_pc2, m_pc3, m_tgt;
    logic [31:0] m_fetch, m_redir;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pend  = 1'b0;
        m_pc1   = RESET_PC;
        m_pc2   = RESET_PC;
        m_pc3   = RESET_PC + 32'd4;
        m_tgt   = '0;
        m_fetch = '0;
        m_redir = '0;
    endtask

    task automatic chk_reset_values(input string tag);
        logic [31:0] rpc;
        rpc = RESET_PC;
        chk({tag, ".imem_en"}, {31'b0, imem_en}, 32'd0);
        chk({tag, ".imem_addr"}, {18'b0, imem_addr}, {18'b0, rpc[AW+1:2]});
        chk({tag, ".instruction_1"}, instruction_1, 32'd0);
        chk({tag, ".pc_1"}, pc_1, RESET_PC);
        chk({tag, ".pc_2"}, pc_2, RESET_PC);
        chk({tag, ".pc_3_plus4"}, pc_3_plus4, RESET_PC + 32'd4);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".fetch_count"}, fetch_count, 32'd0);
        chk({tag, ".redirect_count"}, redirect_count, 32'd0);
`endif
    endtask

    // Asserts reset mid-cycle (asynchronously), checks, then releases just after a rising edge.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_reset_values({tag, ".async"});
        repeat (2) @(posedge clk);
        #1 chk_reset_values({tag, ".held"});
        rst_n = 1'b1;
    endtask

    task automatic cycle(input bit st, input logic [1:0] sel,
                         input logic [31:0] br, input logic [31:0] jt);
        logic [31:0] nxt, live;
        bit          has_live, en_x, bub;
        @(negedge clk);
        stall = st; pc_mux_sel = sel; branch_target = br; jump_target = jt;
        #1;
        has_live = (sel == 2'd1) || (sel == 2'd2);
        live     = ((sel == 2'd2) ? jt : br) & 32'hFFFF_FFFC;
        if (m_boot) begin
            en_x = 1'b1; bub = 1'b1; nxt = RESET_PC;
        end else if (st) begin
            en_x = 1'b0; bub = 1'b0; nxt = '0;
        end else begin
            en_x = 1'b1; bub = m_pend;
            nxt  = m_pend ? m_tgt : (has_live ? live : m_pc1 + 32'd4);
        end
        chk("imem_en", {31'b0, imem_en}, {31'b0, en_x});
        if (en_x) chk("imem_addr", {18'b0, imem_addr}, {18'b0, nxt[AW+1:2]});
        chk("instruction_1", instruction_1, bub ? 32'd0 : mem[m_pc1[AW+1:2]]);
        chk("pc_1", pc_1, m_pc1);
        chk("pc_2", pc_2, m_pc2);
        chk("pc_3_plus4", pc_3_plus4, m_pc3);
`ifdef FETCH_PERF_CNT_EN
        chk("fetch_count", fetch_count, m_fetch);
        chk("redirect_count", redirect_count, m_redir);
`endif
        if (en_x) m_fetch = m_fetch + 32'd1;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (st) begin
            if (has_live) begin
                m_pend = 1'b1;
                m_tgt  = live;
            end
        end else begin
            if (m_pend || has_live) m_redir = m_redir + 32'd1;
            m_pc3  = m_pc2 + 32'd4;
            m_pc2  = m_pc1;
            m_pc1  = nxt;
            m_pend = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'h0050_0093;   // word at RESET_PC
        model_reset();

        do_reset("rst0");

        // Reset release and straight-line fetch
        cycle(0, 2'd0, '0, '0);
        chk("boot.instruction_1", instruction_1, 32'd0);
        cycle(0, 2'd0, '0, '0);
        chk("c2.instruction_1", instruction_1, 32'h0050_0093);
        chk("c2.pc_1", pc_1, 32'h4000_0000);
        cycle(0, 2'd0, '0, '0);
        chk("c3.pc_1", pc_1, 32'h4000_0004);
        chk("c3.pc_2", pc_2, 32'h4000_0000);
        cycle(0, 2'd0, '0, '0);
        chk("c4.pc_3_plus4", pc_3_plus4, 32'h4000_0004);

        // Jump with misaligned target
        cycle(0, 2'd2, 32'h1111_1110, 32'h4000_0102);
        chk("jump.imem_addr", {18'b0, imem_addr}, 32'h0000_0040);
        cycle(0, 2'd0, '0, '0);
        chk("jump.pc_1", pc_1, 32'h4000_0100);

        // Plain 3-cycle stall then resume
        repeat (3) cycle(1, 2'd0, '0, '0);
        cycle(0, 2'd0, '0, '0);
        cycle(0, 2'd0, '0, '0);

        // Branch latched during stall, released with PLUS_4
        cycle(1, 2'd1, 32'h4000_0200, '0);
        cycle(0, 2'd0, '0, '0);
        chk("hredir.instruction_1", instruction_1, 32'd0);
        chk("hredir.imem_addr", {18'b0, imem_addr}, 32'h0000_0080);
        cycle(0, 2'd0, '0, '0);
        chk("hredir.pc_1", pc_1, 32'h4000_0200);

        // PC wrap-around
        cycle(0, 2'd2, '0, 32'hFFFF_FFFF);
        cycle(0, 2'd0, '0, '0);
        chk("wrap.pc_1_top", pc_1, 32'hFFFF_FFFC);
        cycle(0, 2'd0, '0, '0);
        chk("wrap.pc_1_zero", pc_1, 32'h0000_0000);

        // Last redirect during a stall wins
        cycle(1, 2'd1, 32'h4000_1000, '0);
        cycle(1, 2'd2, '0, 32'h4000_2008);
        cycle(1, 2'd0, 32'h4000_3000, '0);
        cycle(0, 2'd0, '0, '0);
        cycle(0, 2'd0, '0, '0);
        chk("lastwins.pc_1", pc_1, 32'h4000_2008);

        // Unused select code behaves as PLUS_4
        cycle(0, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        cycle(0, 2'd0, '0, '0);

        // Stall asserted during BOOT
        do_reset("rst1");
        cycle(1, 2'd2, '0, 32'h4000_0800);
        cycle(1, 2'd0, '0, '0);
        cycle(0, 2'd0, '0, '0);
        cycle(0, 2'd0, '0, '0);

        // Random traffic with a mid-stream reset
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset("rst_mid");
            cycle(($urandom_range(0, 9) < 3), 2'($urandom_range(0, 3)), $urandom, $urandom);
        end

        do_reset("rst_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
